pad_ctrl: RTL and testbench

//  Core-side controller for one bidirectional pad cell. Drives the pad's DIN/OEN/PULL

---
 rtl/pad_ctrl.sv | 137 +++++++++++++
 tb/tb_pad_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pad_ctrl.sv
// pad_ctrl: core-side controller for one bidirectional GPIO pad.
// Drives the pad DIN/OEN/PULL pins from a latched configuration and turns the
// pad DOUT into a synchronised, debounced level with a sticky edge interrupt.
module pad_ctrl #(
  parameter int DEB_W   = 8,
  parameter bit RST_OEN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic             cfg_dir,
  input  logic             cfg_out,
  input  logic [1:0]       cfg_pull,
  input  logic [DEB_W-1:0] cfg_deb,
  input  logic [1:0]       cfg_irq_mode,
  input  logic             irq_clr,
  output logic             pad_din,
  output logic             pad_oen,
  output logic [1:0]       pad_pull,
  input  logic             pad_dout,
  output logic             in_val,
  output logic             irq
);

  typedef enum logic {
    STABLE,
    COUNT
  } deb_state_t;

  deb_state_t       state;
  logic [DEB_W-1:0] deb;
  logic [DEB_W-1:0] cnt;
  logic [1:0]       irq_mode;
  logic             s1;
  logic             s2;
  logic             prev_in_val;
  logic             sample_src;
  logic             rise;
  logic             fall;
  logic             irq_set;

  // While the pad is an output its DOUT may float, so sample our own DIN instead.
  assign sample_src = pad_oen ? pad_dout : pad_din;

  assign rise    = in_val & ~prev_in_val;
  assign fall    = ~in_val & prev_in_val;
  assign irq_set = (rise & irq_mode[0]) | (fall & irq_mode[1]);

  // Latch the configuration; pad pins follow at the same edge as cfg_we.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pad_oen  <= RST_OEN;
      pad_din  <= 1'b0;
      pad_pull <= 2'b00;
      deb      <= '0;
      irq_mode <= 2'b00;
    end else if (cfg_we) begin
      pad_oen  <= cfg_dir;
      pad_din  <= cfg_out;
      pad_pull <= cfg_pull;
      deb      <= cfg_deb;
      irq_mode <= cfg_irq_mode;
    end
  end

  // Two-flop synchroniser for the sampled pad level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sample_src;
      s2 <= s1;
    end
  end

  // Debounce: a new level must persist for N counted cycles before in_val takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= STABLE;
      cnt    <= '0;
      in_val <= 1'b0;
    end else if (deb == '0) begin
      state  <= STABLE;
      cnt    <= '0;
      in_val <= s2;
    end else begin
      case (state)
        STABLE: begin
          if (s2 != in_val) begin
            state <= COUNT;
            cnt   <= DEB_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        COUNT: begin
          if (s2 == in_val) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt >= deb) begin
            in_val <= s2;
            state  <= STABLE;
            cnt    <= '0;
          end else if (cnt != {DEB_W{1'b1}}) begin
            cnt <= cnt + DEB_W'(1);
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Remember the previous debounced level for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_in_val <= 1'b0;
    end else begin
      prev_in_val <= in_val;
    end
  end

  // Sticky interrupt; a new edge beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (irq_set) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pad_ctrl.sv
// tb_pad_ctrl: table-driven and sequence-driven checks of pad_ctrl with a
// cycle scoreboard (expected outputs queued at drive time, compared after the edge).
module tb_pad_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic       cfg_dir;
  logic       cfg_out;
  logic [1:0] cfg_pull;
  logic [7:0] cfg_deb;
  logic [1:0] cfg_irq_mode;
  logic       irq_clr;
  logic       pad_din;
  logic       pad_oen;
  logic [1:0] pad_pull;
  logic       pad_dout;
  logic       in_val;
  logic       irq;

  always #5 clk = ~clk;

  pad_ctrl #(.DEB_W(8), .RST_OEN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_dir(cfg_dir), .cfg_out(cfg_out),
    .cfg_pull(cfg_pull), .cfg_deb(cfg_deb), .cfg_irq_mode(cfg_irq_mode), .irq_clr(irq_clr),
    .pad_din(pad_din), .pad_oen(pad_oen), .pad_pull(pad_pull), .pad_dout(pad_dout),
    .in_val(in_val), .irq(irq)
  );

  typedef struct {
    string      name;
    logic       rst_n;
    logic       cfg_we;
    logic       cfg_dir;
    logic       cfg_out;
    logic [1:0] cfg_pull;
    logic [7:0] cfg_deb;
    logic [1:0] cfg_irq_mode;
    logic       irq_clr;
    logic       pad_dout;
    logic       e_oen;
    logic       e_din;
    logic [1:0] e_pull;
    logic       e_in_val;
    logic       e_irq;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  vec_t mon_v;
  int   checks = 0;
  int   failures = 0;

  logic       c_dir, c_out;
  logic [1:0] c_pull, c_mode;
  logic [7:0] c_deb;
  logic       x_oen, x_din;
  logic [1:0] x_pull;

  function automatic vec_t mk(input string nm, input logic rn, input logic we,
                              input logic dir, input logic out, input logic [1:0] pull,
                              input logic [7:0] deb, input logic [1:0] mode,
                              input logic clr, input logic dout, input logic e_oen,
                              input logic e_din, input logic [1:0] e_pull,
                              input logic e_in, input logic e_irq);
    vec_t v;
    v.name = nm; v.rst_n = rn; v.cfg_we = we; v.cfg_dir = dir; v.cfg_out = out;
    v.cfg_pull = pull; v.cfg_deb = deb; v.cfg_irq_mode = mode; v.irq_clr = clr;
    v.pad_dout = dout; v.e_oen = e_oen; v.e_din = e_din; v.e_pull = e_pull;
    v.e_in_val = e_in; v.e_irq = e_irq;
    return v;
  endfunction

  function automatic void cmp(input string nm, input string f,
                              input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s.%s got=%b exp=%b", nm, f, got, exp);
    end
  endfunction

  function automatic void check_output(input vec_t e);
    cmp(e.name, "pad_oen", {1'b0, pad_oen}, {1'b0, e.e_oen});
    cmp(e.name, "pad_din", {1'b0, pad_din}, {1'b0, e.e_din});
    cmp(e.name, "pad_pull", pad_pull, e.e_pull);
    cmp(e.name, "in_val", {1'b0, in_val}, {1'b0, e.e_in_val});
    cmp(e.name, "irq", {1'b0, irq}, {1'b0, e.e_irq});
  endfunction

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    rst_n        = v.rst_n;
    cfg_we       = v.cfg_we;
    cfg_dir      = v.cfg_dir;
    cfg_out      = v.cfg_out;
    cfg_pull     = v.cfg_pull;
    cfg_deb      = v.cfg_deb;
    cfg_irq_mode = v.cfg_irq_mode;
    irq_clr      = v.irq_clr;
    pad_dout     = v.pad_dout;
    sb.push_back(v);
  endtask

  task automatic step(input string nm, input logic rn, input logic we, input logic clr,
                      input logic dout, input logic e_in, input logic e_irq);
    if (!rn) begin
      x_oen = 1'b1; x_din = 1'b0; x_pull = 2'b00;
    end else if (we) begin
      x_oen = c_dir; x_din = c_out; x_pull = c_pull;
    end
    apply_stimulus(mk(nm, rn, we, c_dir, c_out, c_pull, c_deb, c_mode, clr, dout,
                      x_oen, x_din, x_pull, e_in, e_irq));
  endtask

  // Compare queued expectations just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_v = sb.pop_front();
      check_output(mon_v);
    end
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_dir = 1'b1; cfg_out = 1'b0; cfg_pull = 2'b00;
    cfg_deb = 8'd0; cfg_irq_mode = 2'b00; irq_clr = 1'b0; pad_dout = 1'b0;

    // Reset with random configuration applied at the same time.
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk("reset", 1'b0, 1'b1, 1'($urandom), 1'($urandom), 2'($urandom),
                       8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                       1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
    // Output config, then loopback drives in_val high via bypassed debounce.
    tbl.push_back(mk("cfg_out", 1, 1, 0, 1, 2'b10, 8'd0, 2'b00, 0, 0, 0, 1, 2'b10, 0, 0));
    tbl.push_back(mk("loopback", 1, 0, 0, 1, 2'b10, 8'd0, 2'b00, 0, 0, 0, 1, 2'b10, 0, 0));
    tbl.push_back(mk("loopback", 1, 0, 0, 1, 2'b10, 8'd0, 2'b00, 0, 0, 0, 1, 2'b10, 0, 0));
    tbl.push_back(mk("loopback", 1, 0, 0, 1, 2'b10, 8'd0, 2'b00, 0, 0, 0, 1, 2'b10, 1, 0));
    tbl.push_back(mk("loopback", 1, 0, 0, 1, 2'b10, 8'd0, 2'b00, 0, 0, 0, 1, 2'b10, 1, 0));
    // Back to input, bypass, both edges; clear racing a new set.
    tbl.push_back(mk("bypass", 1, 1, 1, 0, 2'b00, 8'd0, 2'b11, 0, 0, 1, 0, 2'b00, 1, 0));
    tbl.push_back(mk("bypass", 1, 0, 1, 0, 2'b00, 8'd0, 2'b11, 0, 0, 1, 0, 2'b00, 1, 0));
    tbl.push_back(mk("bypass", 1, 0, 1, 0, 2'b00, 8'd0, 2'b11, 0, 0, 1, 0, 2'b00, 1, 0));
    tbl.push_back(mk("bypass_fall", 1, 0, 1, 0, 2'b00, 8'd0, 2'b11, 0, 0, 1, 0, 2'b00, 0, 0));
    tbl.push_back(mk("irq_fall", 1, 0, 1, 0, 2'b00, 8'd0, 2'b11, 0, 1, 1, 0, 2'b00, 0, 1));
    tbl.push_back(mk("irq_clr", 1, 0, 1, 0, 2'b00, 8'd0, 2'b11, 1, 1, 1, 0, 2'b00, 0, 0));
    tbl.push_back(mk("bypass_rise", 1, 0, 1, 0, 2'b00, 8'd0, 2'b11, 0, 1, 1, 0, 2'b00, 1, 0));
    tbl.push_back(mk("set_wins", 1, 0, 1, 0, 2'b00, 8'd0, 2'b11, 1, 1, 1, 0, 2'b00, 1, 1));
    tbl.push_back(mk("sticky", 1, 0, 1, 0, 2'b00, 8'd0, 2'b11, 0, 1, 1, 0, 2'b00, 1, 1));
    tbl.push_back(mk("irq_clr2", 1, 0, 1, 0, 2'b00, 8'd0, 2'b11, 1, 1, 1, 0, 2'b00, 1, 0));

    $display("[TB] table phase, %0d vectors", tbl.size());
    for (int i = 0; i < tbl.size(); i++) apply_stimulus(tbl[i]);

    x_oen = 1'b1; x_din = 1'b0; x_pull = 2'b00;

    // Debounce N=4, rising-only irq: fall first (no irq), then a short pulse, then a held rise.
    c_dir = 1'b1; c_out = 1'b0; c_pull = 2'b00; c_deb = 8'd4; c_mode = 2'b01;
    step("deb_cfg", 1, 1, 0, 0, 1, 0);
    for (int k = 1; k < 9; k++) step("deb_fall", 1, 0, 0, 0, (k < 6), 0);
    for (int k = 0; k < 10; k++) step("pulse", 1, 0, 0, (k < 3), 0, 0);
    for (int k = 0; k < 9; k++) step("deb_rise", 1, 0, 0, 1, (k >= 6), (k >= 7));

    // Large threshold, then lowered mid-count: completes on the next edge.
    c_deb = 8'd200; c_mode = 2'b10;
    step("mid_cfg", 1, 1, 1, 0, 1, 0);
    for (int k = 1; k < 10; k++) step("mid_hold", 1, 0, 0, 0, 1, 0);
    c_deb = 8'd3;
    step("mid_lower", 1, 1, 0, 0, 1, 0);
    step("mid_done", 1, 0, 0, 0, 0, 0);
    step("mid_irq", 1, 0, 0, 0, 0, 1);
    step("mid_irq", 1, 0, 0, 0, 0, 1);

    // Mode change keeps pending irq; reset in the middle of a count.
    c_deb = 8'd5; c_mode = 2'b01; c_pull = 2'b11;
    step("mode_keep", 1, 1, 0, 1, 0, 1);
    for (int k = 1; k < 4; k++) step("counting", 1, 0, 0, 1, 0, 1);
    step("mid_reset", 0, 0, 0, 1, 0, 0);
    step("release", 1, 1, 0, 1, 0, 0);
    for (int k = 1; k < 9; k++) step("redeb", 1, 0, 0, 1, (k >= 7), (k >= 8));

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
